// File: rtl/danmaku_stream_sched.sv
// danmaku_stream_sched: turns a source pixel stream into framed overlay FIFO writes
// (frame marker, line markers, pixel words) with FIFO/source back-pressure.
module danmaku_stream_sched #(
    parameter logic [31:0] FILL_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        blank,
    input  logic [15:0] screenX,
    input  logic [15:0] screenY,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    output logic        src_ready,
    input  logic        fifoAlmostFull,
    output logic        fifoWrreq,
    output logic [31:0] fifoData_out,
    output logic        busy,
    output logic [15:0] frameCnt,
    output logic [15:0] curX,
    output logic [15:0] curY
);
    typedef enum logic [1:0] {IDLE, VMARK, HMARK, PIXELS} state_t;

    state_t      state_q, state_d;
    logic [15:0] limx_q, limx_d, limy_q, limy_d;
    logic [15:0] curx_q, curx_d, cury_q, cury_d;
    logic [15:0] frame_q, frame_d;
    logic        wr_q, wr_d;
    logic [31:0] data_q, data_d;

    logic        dims_ok, emit, slot, line_end, frame_end;
    logic [31:0] word;
    logic        unused_lsbs;

    assign unused_lsbs = ^src_data[6:0];

    assign dims_ok   = (screenX != 16'd0) && (screenY != 16'd0);
    // A zero-sized resolution seen at VMARK abandons the frame instead of writing a marker.
    assign emit      = (state_q == VMARK && dims_ok) || (state_q == HMARK)
                     || (state_q == PIXELS && (blank || src_valid));
    assign slot      = emit && !fifoAlmostFull;
    assign word      = (state_q == VMARK) ? 32'h0000_0002 :
                       (state_q == HMARK) ? 32'h0000_0001 :
                       blank ? FILL_WORD : {src_data[31:7], 7'b0};
    assign line_end  = curx_q == limx_q - 16'd1;
    assign frame_end = line_end && (cury_q == limy_q - 16'd1);

    assign src_ready    = rst && (state_q == PIXELS) && !blank && src_valid && !fifoAlmostFull;
    assign fifoWrreq    = wr_q;
    assign fifoData_out = data_q;
    assign busy         = state_q != IDLE;
    assign frameCnt     = frame_q;
    assign curX         = curx_q;
    assign curY         = cury_q;

    always_comb begin
        state_d = state_q;
        limx_d  = limx_q;
        limy_d  = limy_q;
        curx_d  = curx_q;
        cury_d  = cury_q;
        frame_d = frame_q;
        wr_d    = slot;
        data_d  = slot ? word : data_q;
        case (state_q)
            IDLE: begin
                if (enable && dims_ok)
                    state_d = VMARK;
            end
            VMARK: begin
                if (!dims_ok) begin
                    state_d = IDLE;
                end else if (slot) begin
                    limx_d  = screenX;
                    limy_d  = screenY;
                    curx_d  = 16'd0;
                    cury_d  = 16'd0;
                    state_d = HMARK;
                end
            end
            HMARK: begin
                if (slot) begin
                    curx_d  = 16'd0;
                    state_d = PIXELS;
                end
            end
            PIXELS: begin
                if (slot) begin
                    curx_d = line_end ? 16'd0 : curx_q + 16'd1;
                    if (frame_end) begin
                        frame_d = frame_q + 16'd1;
                        state_d = enable ? VMARK : IDLE;
                    end else if (line_end) begin
                        cury_d  = cury_q + 16'd1;
                        state_d = HMARK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            limx_q  <= 16'd0;
            limy_q  <= 16'd0;
            curx_q  <= 16'd0;
            cury_q  <= 16'd0;
            frame_q <= 16'd0;
            wr_q    <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            limx_q  <= limx_d;
            limy_q  <= limy_d;
            curx_q  <= curx_d;
            cury_q  <= cury_d;
            frame_q <= frame_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_danmaku_stream_sched.sv
// tb_danmaku_stream_sched: scoreboard bench; expected FIFO words are queued as
// stimulus is planned and popped whenever the DUT strobes fifoWrreq.
module tb_danmaku_stream_sched;
    logic        clk = 1'b0;
    logic        rst, enable, blank, src_valid, src_ready, fifoAlmostFull, fifoWrreq, busy;
    logic [15:0] screenX, screenY, frameCnt, curX, curY;
    logic [31:0] src_data, fifoData_out, exp_w;
    logic [31:0] pix [0:1023];
    logic [31:0] sb [$];
    logic        src_en = 1'b1;
    bit          take = 1'b0;
    int          idx = 0, exp_idx = 0, n_vec = 0, n_err = 0, wr_count = 0;

    danmaku_stream_sched dut (
        .clk(clk), .rst(rst), .enable(enable), .blank(blank),
        .screenX(screenX), .screenY(screenY),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .fifoAlmostFull(fifoAlmostFull), .fifoWrreq(fifoWrreq), .fifoData_out(fifoData_out),
        .busy(busy), .frameCnt(frameCnt), .curX(curX), .curY(curY)
    );

    always #5 clk = ~clk;

    assign src_valid = src_en;
    assign src_data  = pix[idx[9:0]];

    // Source model: handshake observed mid-low-phase, pointer advanced just after the edge.
    always @(negedge clk) begin
        #2;
        take = src_ready;
    end
    always @(posedge clk) begin
        #1;
        if (take) idx++;
    end

    always @(negedge clk) begin
        if (rst && fifoWrreq) begin
            n_vec++;
            wr_count++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL stream_extra: got %h, required no write", fifoData_out);
            end else begin
                exp_w = sb.pop_front();
                if (fifoData_out !== exp_w) begin
                    n_err++;
                    $display("FAIL stream_word%0d: got %h, required %h", wr_count, fifoData_out, exp_w);
                end
            end
        end
    end

    function automatic logic [31:0] pix_word(input logic [31:0] d);
        return {d[31:7], 7'b0};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input int w, input int h, input bit blk);
        sb.push_back(32'h0000_0002);
        for (int y = 0; y < h; y++) begin
            sb.push_back(32'h0000_0001);
            for (int x = 0; x < w; x++) begin
                if (blk) sb.push_back(32'h0);
                else begin
                    sb.push_back(pix_word(pix[exp_idx[9:0]]));
                    exp_idx++;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        enable = 1'b0;
        blank = 1'b0;
        fifoAlmostFull = 1'b0;
        src_en = 1'b1;
        screenX = 16'd4;
        screenY = 16'd2;
        tick();
        tick();
        sb.delete();
        rst = 1'b1;
        tick();
        exp_idx = idx;
        wr_count = 0;
    endtask

    task automatic wait_busy(output bit ok);
        int n = 0;
        while (!busy && n < 50) begin tick(); n++; end
        ok = busy;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy && n < 400) begin tick(); n++; end
        ok = !busy;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b1;
        blank = 1'b0;
        fifoAlmostFull = 1'b0;
        screenX = 16'd4;
        screenY = 16'd2;
        tick();
        n_vec++; if (fifoWrreq !== 1'b0)     begin n_err++; $display("FAIL rst_wrreq: got %b, required 0", fifoWrreq); end
        n_vec++; if (fifoData_out !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h, required 0", fifoData_out); end
        n_vec++; if (frameCnt !== 16'h0)     begin n_err++; $display("FAIL rst_frame: got %h, required 0", frameCnt); end
        n_vec++; if (curX !== 16'h0)         begin n_err++; $display("FAIL rst_curx: got %h, required 0", curX); end
        n_vec++; if (curY !== 16'h0)         begin n_err++; $display("FAIL rst_cury: got %h, required 0", curY); end
        n_vec++; if (busy !== 1'b0)          begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_vec++; if (src_ready !== 1'b0)     begin n_err++; $display("FAIL rst_srcrdy: got %b, required 0", src_ready); end
        enable = 1'b0;
    endtask

    task automatic test_frame();
        bit ok;
        int n = 0;
        do_reset();
        pix[idx[9:0]] = 32'hAABBCC85;
        n_vec++;
        if (pix_word(pix[idx[9:0]]) !== 32'hAABBCC80) begin
            n_err++;
            $display("FAIL pixel_format: got %h, required aabbcc80", pix_word(pix[idx[9:0]]));
        end
        push_frame(4, 2, 1'b0);
        push_frame(4, 2, 1'b0);
        enable = 1'b1;
        while (wr_count < 11 && n < 100) begin
            tick();
            n++;
            if (wr_count == 10) begin
                n_vec++;
                if (frameCnt !== 16'd0) begin n_err++; $display("FAIL frame_cnt_early: got %0d, required 0", frameCnt); end
            end
        end
        n_vec++; if (wr_count != 11)   begin n_err++; $display("FAIL frame_writes: got %0d, required 11", wr_count); end
        n_vec++; if (frameCnt !== 16'd1) begin n_err++; $display("FAIL frame_cnt1: got %0d, required 1", frameCnt); end
        enable = 1'b0;
        wait_idle(ok);
        n_vec++; if (!ok)              begin n_err++; $display("FAIL frame_idle: busy=%b, required 0", busy); end
        n_vec++; if (sb.size() != 0)   begin n_err++; $display("FAIL frame_drain: got %0d left, required 0", sb.size()); end
        n_vec++; if (frameCnt !== 16'd2) begin n_err++; $display("FAIL frame_cnt2: got %0d, required 2", frameCnt); end
    endtask

    task automatic test_stall();
        bit ok;
        int n = 0;
        do_reset();
        push_frame(4, 2, 1'b0);
        enable = 1'b1;
        wait_busy(ok);
        enable = 1'b0;
        while (!(curX == 16'd2 && curY == 16'd0 && busy) && n < 50) begin tick(); n++; end
        n_vec++; if (curX !== 16'd2) begin n_err++; $display("FAIL stall_reach: curX=%0d, required 2", curX); end
        fifoAlmostFull = 1'b1;
        #1;
        n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL stall_rdy0: got %b, required 0", src_ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (fifoWrreq !== 1'b0) begin n_err++; $display("FAIL stall_wrreq%0d: got %b, required 0", i, fifoWrreq); end
            n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL stall_rdy%0d: got %b, required 0", i, src_ready); end
        end
        n_vec++; if (curX !== 16'd2) begin n_err++; $display("FAIL stall_hold: curX=%0d, required 2", curX); end
        fifoAlmostFull = 1'b0;
        n = 0;
        while (!(curX == 16'd1 && curY == 16'd1) && n < 50) begin tick(); n++; end
        src_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (fifoWrreq !== 1'b0) begin n_err++; $display("FAIL novalid_wrreq%0d: got %b, required 0", i, fifoWrreq); end
        end
        n_vec++; if (curX !== 16'd1) begin n_err++; $display("FAIL novalid_hold: curX=%0d, required 1", curX); end
        src_en = 1'b1;
        wait_idle(ok);
        n_vec++; if (!ok)            begin n_err++; $display("FAIL stall_idle: busy=%b, required 0", busy); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL stall_drain: got %0d left, required 0", sb.size()); end
        n_vec++; if (idx != exp_idx) begin n_err++; $display("FAIL stall_consumed: got %0d, required %0d", idx, exp_idx); end
    endtask

    task automatic test_blank();
        int  rdy_hits = 0, n = 0;
        bit  seen = 1'b0;
        do_reset();
        blank = 1'b1;
        push_frame(4, 2, 1'b1);
        enable = 1'b1;
        while (!(seen && !busy) && n < 100) begin
            tick();
            n++;
            if (src_ready !== 1'b0) rdy_hits++;
            if (busy) begin seen = 1'b1; enable = 1'b0; end
        end
        n_vec++; if (rdy_hits != 0)  begin n_err++; $display("FAIL blank_rdy: got %0d asserted cycles, required 0", rdy_hits); end
        n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL blank_idle: busy=%b, required 0", busy); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL blank_drain: got %0d left, required 0", sb.size()); end
        n_vec++; if (idx != exp_idx) begin n_err++; $display("FAIL blank_consumed: got %0d, required %0d", idx, exp_idx); end
        blank = 1'b0;
    endtask

    task automatic test_enable_drop();
        bit ok;
        int n = 0;
        do_reset();
        push_frame(4, 2, 1'b0);
        enable = 1'b1;
        while (!(curX == 16'd1 && curY == 16'd0 && busy) && n < 50) begin tick(); n++; end
        enable = 1'b0;
        wait_idle(ok);
        n_vec++; if (!ok)              begin n_err++; $display("FAIL drop_idle: busy=%b, required 0", busy); end
        n_vec++; if (frameCnt !== 16'd1) begin n_err++; $display("FAIL drop_frame: got %0d, required 1", frameCnt); end
        n_vec++; if (sb.size() != 0)   begin n_err++; $display("FAIL drop_drain: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        do_reset();
        push_frame(4, 2, 1'b0);
        enable = 1'b1;
        while (!(curY == 16'd1 && busy) && n < 50) begin tick(); n++; end
        rst = 1'b0;
        #1;
        n_vec++; if (fifoWrreq !== 1'b0)     begin n_err++; $display("FAIL midrst_wrreq: got %b, required 0", fifoWrreq); end
        n_vec++; if (fifoData_out !== 32'h0) begin n_err++; $display("FAIL midrst_data: got %h, required 0", fifoData_out); end
        n_vec++; if (curY !== 16'h0)         begin n_err++; $display("FAIL midrst_cury: got %0d, required 0", curY); end
        n_vec++; if (busy !== 1'b0)          begin n_err++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        n_vec++; if (src_ready !== 1'b0)     begin n_err++; $display("FAIL midrst_rdy: got %b, required 0", src_ready); end
        sb.delete();
        exp_idx = idx;
        push_frame(4, 2, 1'b0);
        tick();
        rst = 1'b1;
        n = 0;
        while (!fifoWrreq && n < 20) begin tick(); n++; end
        n_vec++; if (fifoWrreq !== 1'b1 || fifoData_out !== 32'h2) begin
            n_err++; $display("FAIL midrst_first: got %b/%h, required 1/00000002", fifoWrreq, fifoData_out);
        end
        enable = 1'b0;
        wait_idle(ok);
        n_vec++; if (!ok)              begin n_err++; $display("FAIL midrst_idle: busy=%b, required 0", busy); end
        n_vec++; if (sb.size() != 0)   begin n_err++; $display("FAIL midrst_drain: got %0d left, required 0", sb.size()); end
        n_vec++; if (frameCnt !== 16'd1) begin n_err++; $display("FAIL midrst_frame: got %0d, required 1", frameCnt); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) pix[i] = $urandom;
        rst = 1'b0;
        enable = 1'b0;
        blank = 1'b0;
        fifoAlmostFull = 1'b0;
        screenX = 16'd4;
        screenY = 16'd2;
        test_reset();
        test_frame();
        test_stall();
        test_blank();
        test_enable_drop();
        test_reset_mid();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
